key_press_conditioner: RTL and testbench
========================================

Name: key_press_conditioner

Overview:
- Upstream stage of the digital lock FSM.
- Takes the already-synchronised KEY bus and debounces each bit.
- Converts clean key activity into single-cycle, one-hot press events. Rejects multi-key chords.
- The lock FSM consumes keyPress/keyCode instead of raw levels, so each physical press advances the combination exactly once.

Parameters:
- WIDTH, 4: number of key inputs.
- DEBOUNCE_CYCLES, 50000: consecutive stable cycles needed before a bit's debounced value changes. Minimum 2. Counter width is clog2(DEBOUNCE_CYCLES).
- REPEAT_CYCLES, 25000000: auto-repeat period. Used only when KEY_AUTOREPEAT_EN is defined.

Ports:
- clock, input, 1: system clock; all state on rising edge.
- reset, input, 1: asynchronous, active-low reset.
- keySync, input, WIDTH: synchronised key levels; 1 = pressed.
- keyPress, output, 1: one-cycle pulse, one per accepted press.
- keyCode, output, WIDTH: one-hot code of the last accepted key; held between presses.
- keyHeld, output, 1: level; an accepted key is still down.
- multiKey, output, 1: one-cycle pulse when a chord (more than one bit) is detected.

Behaviour:
- Reset (reset=0, asynchronous): all outputs 0, debounced vector 0, all counters 0, FSM in IDLE.
- Debounce, per bit, independent:
  - If keySync[i] equals deb[i], the bit's counter clears.
  - Otherwise the counter increments.
  - When the counter reaches DEBOUNCE_CYCLES-1 and the input still differs, deb[i] takes the input value and the counter clears.
  - A glitch shorter than DEBOUNCE_CYCLES resets the count with no effect on deb[i].
  - Latency from a stable input edge to a deb change is exactly DEBOUNCE_CYCLES cycles.
- FSM states: IDLE, PRESSED, RELEASE_WAIT. All decisions use deb only.
- IDLE:
  - deb all zero: stay.
  - deb one-hot: next cycle keyPress=1 and keyCode=deb; go to PRESSED.
  - deb has more than one bit set: next cycle multiKey=1; go to RELEASE_WAIT; keyCode unchanged.
- PRESSED:
  - keyHeld=1.
  - Extra bits appearing: no new event, stay.
  - deb all zero: go to IDLE and deassert keyHeld on the next cycle.
- RELEASE_WAIT:
  - No events.
  - deb all zero: go to IDLE.
- A new press is accepted only after a full release. Key A released and key B pressed in the same debounced cycle gives no B event until all keys are released.
- keyPress and multiKey are never high in the same cycle.
- Maximum press rate: one per release/press pair.
- Reset mid-press: outputs return to 0 immediately. After reset release, a key still held is debounced from 0, so a press is reported again after DEBOUNCE_CYCLES.

Optional Feature:
- Macro: KEY_AUTOREPEAT_EN.
- Defined:
  - In PRESSED with the original key still sole in deb, a repeat counter runs.
  - Every REPEAT_CYCLES cycles it issues another keyPress with the same keyCode.
  - The counter clears on entering PRESSED and whenever deb is not exactly keyCode. While any extra bit is set, no repeats occur.
- Undefined: no repeat counter logic. Exactly one keyPress per hold regardless of duration.

Test Plan (DEBOUNCE_CYCLES=4, REPEAT_CYCLES=10 unless noted):
- Hold keySync=4'b0010 for 20 cycles from reset → keyPress pulses once, 5 cycles after the edge; keyCode=4'b0010; keyHeld=1 until 5 cycles after release.
- Pulse keySync=4'b0001 for 3 cycles only (bounce) → no keyPress, keyCode stays 0.
- Apply 4'b0101 simultaneously → single multiKey pulse, no keyPress. Release, then apply 4'b0100 → keyPress with keyCode=4'b0100.
- Press 4'b1000, then add 4'b0001 while held, release 4'b1000, keep 4'b0001 → exactly one keyPress (code 4'b1000). No event until all keys released.
- Assert reset=0 while in PRESSED with 4'b0010 held → all outputs 0 immediately. After reset=1, keyPress reissued after 4+1 cycles.
- KEY_AUTOREPEAT_EN defined, hold 4'b0001 for 40 cycles → first keyPress, then keyPress every 10 cycles, 4 pulses total, keyCode constant. Without the macro: 1 pulse.

Source files
------------

// File: rtl/key_press_conditioner_if.sv
// ---------------------------------------------------------------------------
// key_press_conditioner_if
//
// Bundles the key-side signals of key_press_conditioner.
//
// Signals:
//   keySync  - synchronised key levels, 1 = pressed (driven by master)
//   keyPress - one-cycle pulse per accepted press (driven by slave)
//   keyCode  - one-hot code of the last accepted key, held (driven by slave)
//   keyHeld  - level, an accepted key is still down (driven by slave)
//   multiKey - one-cycle pulse when a chord is detected (driven by slave)
//
// Modports:
//   master - key source / event consumer side (drives keySync)
//   slave  - the conditioner itself (drives the event outputs)
// ---------------------------------------------------------------------------
interface key_press_conditioner_if #(
  parameter int WIDTH = 4
);
  logic [WIDTH-1:0] keySync;
  logic             keyPress;
  logic [WIDTH-1:0] keyCode;
  logic             keyHeld;
  logic             multiKey;

  modport master (
    output keySync,
    input  keyPress,
    input  keyCode,
    input  keyHeld,
    input  multiKey
  );

  modport slave (
    input  keySync,
    output keyPress,
    output keyCode,
    output keyHeld,
    output multiKey
  );
endinterface

// File: rtl/key_press_conditioner.sv
// ---------------------------------------------------------------------------
// key_press_conditioner
//
// Debounces each bit of the synchronised key bus independently and turns
// clean key activity into single-cycle, one-hot press events for the lock
// FSM. Multi-key chords are rejected with a multiKey pulse, and a new press
// is only accepted after every key has been released.
//
// Parameters:
//   WIDTH           - number of key inputs
//   DEBOUNCE_CYCLES - consecutive differing cycles before a debounced bit
//                     changes (minimum 2)
//   REPEAT_CYCLES   - auto-repeat period, only used with KEY_AUTOREPEAT_EN
//
// Optional feature (compile-time macro KEY_AUTOREPEAT_EN):
//   When defined, holding a single accepted key re-issues keyPress with the
//   same keyCode every REPEAT_CYCLES cycles. When undefined there is no
//   repeat logic and each hold produces exactly one keyPress.
//
// Ports:
//   clock - system clock, all state on the rising edge
//   reset - asynchronous, active-low reset
//   bus   - key_press_conditioner_if.slave
//             keySync  (in)  synchronised key levels
//             keyPress (out) one-cycle press pulse
//             keyCode  (out) one-hot code of last accepted key
//             keyHeld  (out) accepted key still down
//             multiKey (out) one-cycle chord pulse
// ---------------------------------------------------------------------------
module key_press_conditioner #(
  parameter int WIDTH           = 4,
  parameter int DEBOUNCE_CYCLES = 50000,
  parameter int REPEAT_CYCLES   = 25000000
) (
  input  logic                    clock,
  input  logic                    reset,
  key_press_conditioner_if.slave  bus
);

  localparam int             CNT_W    = $clog2(DEBOUNCE_CYCLES);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  // A one-cycle debounce window or a zero-length repeat period would make
  // the counters degenerate, so refuse to elaborate such a configuration.
  if (DEBOUNCE_CYCLES < 2 || REPEAT_CYCLES < 2) begin : g_param_check
    $error("key_press_conditioner: DEBOUNCE_CYCLES and REPEAT_CYCLES must be >= 2");
  end

  typedef enum logic [1:0] {
    IDLE,
    PRESSED,
    RELEASE_WAIT
  } state_t;

  logic [CNT_W-1:0] cnt [WIDTH];
  logic [WIDTH-1:0] deb;

  state_t           state;
  state_t           state_next;

  logic             press_r;
  logic             press_next;
  logic             multi_r;
  logic             multi_next;
  logic             held_r;
  logic             held_next;
  logic [WIDTH-1:0] code_r;
  logic [WIDTH-1:0] code_next;

  logic             deb_any;
  logic             deb_onehot;

`ifdef KEY_AUTOREPEAT_EN
  localparam int             REP_W    = $clog2(REPEAT_CYCLES);
  localparam logic [REP_W-1:0] REP_LAST = REP_W'(REPEAT_CYCLES - 1);

  logic [REP_W-1:0] rep_cnt;
  logic             rep_due;
`endif

  // ---- Stage: per-bit debounce ------------------------------------------
  // A bit's counter only runs while the raw input disagrees with the
  // debounced value, so any glitch back to the debounced level restarts the
  // count and never disturbs deb.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      deb <= '0;
      for (int i = 0; i < WIDTH; i++) begin
        cnt[i] <= '0;
      end
    end else begin
      for (int i = 0; i < WIDTH; i++) begin
        if (bus.keySync[i] == deb[i]) begin
          cnt[i] <= '0;
        end else if (cnt[i] == CNT_LAST) begin
          deb[i] <= bus.keySync[i];
          cnt[i] <= '0;
        end else begin
          cnt[i] <= cnt[i] + 1'b1;
        end
      end
    end
  end

  assign deb_any    = (deb != '0);
  // Clearing the lowest set bit leaves zero only for a single-bit vector.
  assign deb_onehot = deb_any && ((deb & (deb - 1'b1)) == '0);

`ifdef KEY_AUTOREPEAT_EN
  // ---- Stage: auto-repeat timer -----------------------------------------
  // Runs only while the accepted key is the sole key down; any extra bit,
  // a release or leaving PRESSED restarts the period.
  assign rep_due = (state == PRESSED) && (deb == code_r) && (rep_cnt == REP_LAST);

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      rep_cnt <= '0;
    end else if ((state != PRESSED) || (deb != code_r) || rep_due) begin
      rep_cnt <= '0;
    end else begin
      rep_cnt <= rep_cnt + 1'b1;
    end
  end
`endif

  // ---- Stage: event FSM --------------------------------------------------
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    press_next = 1'b0;
    multi_next = 1'b0;
    code_next  = code_r;

    case (state)
      IDLE: begin
        if (deb_onehot) begin
          press_next = 1'b1;
          code_next  = deb;
          state_next = PRESSED;
        end else if (deb_any) begin
          // Chord: report it, but keep the previous code for the lock FSM.
          multi_next = 1'b1;
          state_next = RELEASE_WAIT;
        end
      end

      PRESSED: begin
        // Extra keys joining an accepted press are ignored until every key
        // is up; this also swallows an A-release/B-press in the same cycle.
        if (!deb_any) begin
          state_next = IDLE;
        end
`ifdef KEY_AUTOREPEAT_EN
        else if (rep_due) begin
          press_next = 1'b1;
        end
`endif
      end

      RELEASE_WAIT: begin
        if (!deb_any) begin
          state_next = IDLE;
        end
      end

      default: begin
        state_next = IDLE;
      end
    endcase

    held_next = (state_next == PRESSED);
  end

  // ---- Stage: registered outputs ----------------------------------------
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      press_r <= 1'b0;
      multi_r <= 1'b0;
      held_r  <= 1'b0;
      code_r  <= '0;
    end else begin
      press_r <= press_next;
      multi_r <= multi_next;
      held_r  <= held_next;
      code_r  <= code_next;
    end
  end

  assign bus.keyPress = press_r;
  assign bus.multiKey = multi_r;
  assign bus.keyHeld  = held_r;
  assign bus.keyCode  = code_r;

endmodule

// File: tb/tb_key_press_conditioner.sv
module tb_key_press_conditioner;

  localparam int WIDTH = 4;
  localparam int DEB   = 4;
  localparam int REP   = 10;

  logic clock = 1'b0;
  logic reset = 1'b0;

  key_press_conditioner_if #(.WIDTH(WIDTH)) bus ();

  key_press_conditioner #(
    .WIDTH          (WIDTH),
    .DEBOUNCE_CYCLES(DEB),
    .REPEAT_CYCLES  (REP)
  ) dut (
    .clock(clock),
    .reset(reset),
    .bus  (bus.slave)
  );

  always #5 clock = ~clock;

  int checks = 0;
  int errors = 0;

  // Reference model: a bit's debounced value flips once the last DEB
  // samples all disagree with it; events follow the "accept only after a
  // full release" rule.
  logic [WIDTH-1:0] hist [$];
  logic [WIDTH-1:0] m_deb;
  logic [WIDTH-1:0] m_code;
  bit               m_ready;
  bit               m_hold;
  bit               m_press;
  bit               m_multi;
  int               m_rep;

  task automatic model_reset();
    hist.delete();
    m_deb   = '0;
    m_code  = '0;
    m_ready = 1'b1;
    m_hold  = 1'b0;
    m_press = 1'b0;
    m_multi = 1'b0;
    m_rep   = 0;
  endtask

  task automatic model_step(input logic [WIDTH-1:0] key);
    bit all_diff;
    m_press = 1'b0;
    m_multi = 1'b0;
    if (m_ready) begin
      if (m_deb != '0) begin
        m_ready = 1'b0;
        if ($countones(m_deb) == 1) begin
          m_press = 1'b1;
          m_code  = m_deb;
          m_hold  = 1'b1;
          m_rep   = 0;
        end else begin
          m_multi = 1'b1;
          m_hold  = 1'b0;
        end
      end
    end else if (m_deb == '0) begin
      m_ready = 1'b1;
      m_hold  = 1'b0;
    end
`ifdef KEY_AUTOREPEAT_EN
    else if (m_hold) begin
      if (m_deb == m_code) begin
        m_rep++;
        if (m_rep == REP) begin
          m_press = 1'b1;
          m_rep   = 0;
        end
      end else begin
        m_rep = 0;
      end
    end
`endif
    hist.push_back(key);
    if (hist.size() > DEB) void'(hist.pop_front());
    if (hist.size() == DEB) begin
      for (int b = 0; b < WIDTH; b++) begin
        all_diff = 1'b1;
        foreach (hist[j]) if (hist[j][b] == m_deb[b]) all_diff = 1'b0;
        if (all_diff) m_deb[b] = ~m_deb[b];
      end
    end
  endtask

  task automatic tick();
    @(posedge clock);
    if (!reset) model_reset();
    else model_step(bus.keySync);
    #1;
  endtask

  task automatic apply_reset();
    bus.keySync = '0;
    reset = 1'b0;
    model_reset();
    repeat (2) @(posedge clock);
    #1;
    reset = 1'b1;
  endtask

  task automatic test_reset();
    bus.keySync = 4'b1111;
    reset = 1'b0;
    model_reset();
    repeat (3) @(posedge clock);
    #1;
    checks++; if (bus.keyPress !== 1'b0) begin errors++; $display("FAIL reset_keyPress: got %b expected 0", bus.keyPress); end
    checks++; if (bus.keyCode !== 4'b0000) begin errors++; $display("FAIL reset_keyCode: got %b expected 0000", bus.keyCode); end
    checks++; if (bus.keyHeld !== 1'b0) begin errors++; $display("FAIL reset_keyHeld: got %b expected 0", bus.keyHeld); end
    checks++; if (bus.multiKey !== 1'b0) begin errors++; $display("FAIL reset_multiKey: got %b expected 0", bus.multiKey); end
  endtask

  task automatic test_single_press();
    int npress = 0;
    int first = 0;
    apply_reset();
    bus.keySync = 4'b0010;
    for (int k = 1; k <= 20; k++) begin
      tick();
      if (bus.keyPress === 1'b1) begin
        npress++;
        if (first == 0) first = k;
      end
    end
    checks++; if (first != 5) begin errors++; $display("FAIL single_latency: got %0d expected 5", first); end
    checks++; if (npress != 1) begin errors++; $display("FAIL single_count: got %0d expected 1", npress); end
    checks++; if (bus.keyCode !== 4'b0010) begin errors++; $display("FAIL single_code: got %b expected 0010", bus.keyCode); end
    bus.keySync = 4'b0000;
    for (int k = 1; k <= 6; k++) begin
      tick();
      checks++;
      if (bus.keyHeld !== (k < 5)) begin
        errors++; $display("FAIL single_held_release: cycle %0d got %b expected %b", k, bus.keyHeld, (k < 5));
      end
    end
  endtask

  task automatic test_bounce();
    int npress = 0;
    apply_reset();
    bus.keySync = 4'b0001;
    repeat (3) begin tick(); if (bus.keyPress === 1'b1) npress++; end
    bus.keySync = 4'b0000;
    repeat (8) begin tick(); if (bus.keyPress === 1'b1) npress++; end
    checks++; if (npress != 0) begin errors++; $display("FAIL bounce_count: got %0d expected 0", npress); end
    checks++; if (bus.keyCode !== 4'b0000) begin errors++; $display("FAIL bounce_code: got %b expected 0000", bus.keyCode); end
  endtask

  task automatic test_chord();
    int npress = 0;
    int nmulti = 0;
    int mfirst = 0;
    apply_reset();
    bus.keySync = 4'b0101;
    for (int k = 1; k <= 8; k++) begin
      tick();
      if (bus.keyPress === 1'b1) npress++;
      if (bus.multiKey === 1'b1) begin nmulti++; if (mfirst == 0) mfirst = k; end
    end
    checks++; if (nmulti != 1 || mfirst != 5) begin errors++; $display("FAIL chord_multi: got %0d pulses at %0d expected 1 at 5", nmulti, mfirst); end
    checks++; if (npress != 0) begin errors++; $display("FAIL chord_nopress: got %0d expected 0", npress); end
    checks++; if (bus.keyCode !== 4'b0000) begin errors++; $display("FAIL chord_code: got %b expected 0000", bus.keyCode); end
    bus.keySync = 4'b0000;
    repeat (6) tick();
    bus.keySync = 4'b0100;
    npress = 0;
    mfirst = 0;
    for (int k = 1; k <= 8; k++) begin
      tick();
      if (bus.keyPress === 1'b1) begin npress++; if (mfirst == 0) mfirst = k; end
    end
    checks++; if (npress != 1 || mfirst != 5) begin errors++; $display("FAIL chord_after_press: got %0d pulses at %0d expected 1 at 5", npress, mfirst); end
    checks++; if (bus.keyCode !== 4'b0100) begin errors++; $display("FAIL chord_after_code: got %b expected 0100", bus.keyCode); end
  endtask

  task automatic test_overlap();
    int npress = 0;
    int nmulti = 0;
    apply_reset();
    bus.keySync = 4'b1000;
    repeat (8) begin tick(); if (bus.keyPress === 1'b1) npress++; if (bus.multiKey === 1'b1) nmulti++; end
    bus.keySync = 4'b1001;
    repeat (8) begin tick(); if (bus.keyPress === 1'b1) npress++; if (bus.multiKey === 1'b1) nmulti++; end
    bus.keySync = 4'b0001;
    repeat (12) begin tick(); if (bus.keyPress === 1'b1) npress++; if (bus.multiKey === 1'b1) nmulti++; end
    checks++; if (npress != 1) begin errors++; $display("FAIL overlap_count: got %0d expected 1", npress); end
    checks++; if (nmulti != 0) begin errors++; $display("FAIL overlap_multi: got %0d expected 0", nmulti); end
    checks++; if (bus.keyCode !== 4'b1000) begin errors++; $display("FAIL overlap_code: got %b expected 1000", bus.keyCode); end
    checks++; if (bus.keyHeld !== 1'b1) begin errors++; $display("FAIL overlap_held: got %b expected 1", bus.keyHeld); end
    bus.keySync = 4'b0000;
    repeat (8) tick();
    checks++; if (bus.keyHeld !== 1'b0) begin errors++; $display("FAIL overlap_released: got %b expected 0", bus.keyHeld); end
    bus.keySync = 4'b0001;
    npress = 0;
    repeat (8) begin tick(); if (bus.keyPress === 1'b1) npress++; end
    checks++; if (npress != 1 || bus.keyCode !== 4'b0001) begin errors++; $display("FAIL overlap_repress: got %0d pulses code %b expected 1 code 0001", npress, bus.keyCode); end
  endtask

  task automatic test_reset_mid_press();
    int npress = 0;
    int first = 0;
    apply_reset();
    bus.keySync = 4'b0010;
    repeat (8) tick();
    checks++; if (bus.keyHeld !== 1'b1) begin errors++; $display("FAIL midreset_pre_held: got %b expected 1", bus.keyHeld); end
    #2;
    reset = 1'b0;
    model_reset();
    #1;
    checks++; if (bus.keyHeld !== 1'b0) begin errors++; $display("FAIL midreset_held: got %b expected 0", bus.keyHeld); end
    checks++; if (bus.keyCode !== 4'b0000) begin errors++; $display("FAIL midreset_code: got %b expected 0000", bus.keyCode); end
    checks++; if (bus.keyPress !== 1'b0 || bus.multiKey !== 1'b0) begin errors++; $display("FAIL midreset_pulses: got %b%b expected 00", bus.keyPress, bus.multiKey); end
    repeat (2) tick();
    reset = 1'b1;
    for (int k = 1; k <= 8; k++) begin
      tick();
      if (bus.keyPress === 1'b1) begin npress++; if (first == 0) first = k; end
    end
    checks++; if (npress != 1 || first != 5) begin errors++; $display("FAIL midreset_repress: got %0d pulses at %0d expected 1 at 5", npress, first); end
    checks++; if (bus.keyCode !== 4'b0010) begin errors++; $display("FAIL midreset_recode: got %b expected 0010", bus.keyCode); end
  endtask

  task automatic test_autorepeat();
    int npress = 0;
    int exp_n;
`ifdef KEY_AUTOREPEAT_EN
    exp_n = 4;
`else
    exp_n = 1;
`endif
    apply_reset();
    bus.keySync = 4'b0001;
    repeat (40) begin
      tick();
      if (bus.keyPress === 1'b1) begin
        npress++;
        checks++;
        if (bus.keyCode !== 4'b0001) begin errors++; $display("FAIL repeat_code: got %b expected 0001", bus.keyCode); end
      end
    end
    checks++; if (npress != exp_n) begin errors++; $display("FAIL repeat_count: got %0d expected %0d", npress, exp_n); end
    bus.keySync = 4'b0000;
    repeat (8) tick();
  endtask

  task automatic test_random();
    int run = 0;
    logic [WIDTH-1:0] v;
    apply_reset();
    for (int n = 0; n < 1500; n++) begin
      if (run == 0) begin
        int r;
        r = $urandom_range(0, 9);
        v = '0;
        if (r >= 3 && r <= 6) v[$urandom_range(0, WIDTH-1)] = 1'b1;
        else if (r > 6) v = WIDTH'($urandom);
        bus.keySync = v;
        run = $urandom_range(1, 8);
      end
      run--;
      tick();
      checks++; if (bus.keyPress !== m_press) begin errors++; $display("FAIL rand_keyPress: cycle %0d got %b expected %b", n, bus.keyPress, m_press); end
      checks++; if (bus.multiKey !== m_multi) begin errors++; $display("FAIL rand_multiKey: cycle %0d got %b expected %b", n, bus.multiKey, m_multi); end
      checks++; if (bus.keyHeld !== m_hold) begin errors++; $display("FAIL rand_keyHeld: cycle %0d got %b expected %b", n, bus.keyHeld, m_hold); end
      checks++; if (bus.keyCode !== m_code) begin errors++; $display("FAIL rand_keyCode: cycle %0d got %b expected %b", n, bus.keyCode, m_code); end
      checks++; if (bus.keyPress === 1'b1 && bus.multiKey === 1'b1) begin errors++; $display("FAIL rand_exclusive: cycle %0d got 11 expected not both", n); end
    end
  endtask

  initial begin
    bus.keySync = '0;
    model_reset();
    test_reset();
    test_single_press();
    test_bounce();
    test_chord();
    test_overlap();
    test_reset_mid_press();
    test_autorepeat();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
